// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    // Bit-counter width; at least one bit so a 1-bit input still builds.
    function automatic int unsigned cnt_width(input int unsigned bin_w);
        return (bin_w > 1) ? $clog2(bin_w) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_LZB_EN to blank leading zero digits with 4'hF.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = cnt_width(BIN_W);

`ifdef BIN2BCD_LZB_EN
    localparam logic [BW-1:0] BCD_RST = {BW{1'b1}} << 4;
`else
    localparam logic [BW-1:0] BCD_RST = '0;
`endif

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bcd_work;
    logic [BIN_W-1:0]       bin_work;
    logic [BW-1:0]          bcd_adj;
    logic [BW+BIN_W-1:0]    shifted;
    logic [BW-1:0]          bcd_final;
    logic                   sticky;
    logic                   last;
    logic                   out_bit;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (bcd_work[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    assign shifted = {bcd_adj[BW-2:0], bin_work, 1'b0};
    assign out_bit = bcd_adj[BW-1];
    assign last    = (cnt == CW'(BIN_W - 1));
    assign busy    = (state == SHIFT);

`ifdef BIN2BCD_LZB_EN
    // Walk down from the top digit, blanking zeros until the first non-zero; digit 0 always shows.
    always_comb begin
        logic lead;
        lead      = 1'b1;
        bcd_final = shifted[BW+BIN_W-1:BIN_W];
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (bcd_final[4*i +: 4] == 4'h0)) begin
                bcd_final[4*i +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign bcd_final = shifted[BW+BIN_W-1:BIN_W];
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            bcd_work <= '0;
            bin_work <= '0;
            sticky   <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            bcd      <= BCD_RST;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_work <= '0;
                        bin_work <= bin;
                        sticky   <= 1'b0;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    {bcd_work, bin_work} <= shifted;
                    sticky               <= sticky | out_bit;
                    cnt                  <= cnt + 1'b1;
                    if (last) begin
                        bcd  <= bcd_final;
                        ovf  <= sticky | out_bit;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
